// File: rtl/cond_exec_unit.sv
// cond_exec_unit: EXE-stage condition evaluation with architectural NZCV
// storage and Thumb-style If-Then (IT) block sequencing. exec_en gates
// register writeback, memory write and branch-taken for the current
// instruction; it is combinational against the registered (pre-edge) flags.
module cond_exec_unit #(
    parameter int          IT_MAX       = 4,
    parameter logic [3:0]  RESET_STATUS = 4'b0000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           flush,
    input  logic                           instr_valid,
    input  logic [3:0]                     instr_cond,
    input  logic                           it_start,
    input  logic [3:0]                     it_firstcond,
    input  logic [$clog2(IT_MAX+1)-1:0]    it_len,
    input  logic [IT_MAX-1:0]              it_tmask,
    input  logic                           status_we,
    input  logic [3:0]                     status_in,
    output logic [3:0]                     status_out,
    output logic                           exec_en,
    output logic [3:0]                     eff_cond,
    output logic                           in_it,
    output logic [$clog2(IT_MAX+1)-1:0]    it_remaining,
    output logic                           it_err
);

    localparam int LW = $clog2(IT_MAX + 1);

    // IT sequencer states
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [LW-1:0] IT_MAX_L = LW'(IT_MAX);
    localparam logic [LW-1:0] ONE_L    = LW'(1);

    // Registered state
    logic [0:0]        state_q,     state_d;
    logic [3:0]        status_q,    status_d;
    logic [3:0]        firstcond_q, firstcond_d;
    logic [IT_MAX-1:0] mask_q,      mask_d;
    logic [LW-1:0]     rem_q,       rem_d;
    logic              it_err_q,    it_err_d;

    // Combinational helpers
    logic              consume;
    logic              active;
    logic              cond_pass;
    logic [LW-1:0]     len_clamped;

    // ARM condition-code truth table against {N,Z,C,V}
    function automatic logic cond_truth(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic res;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'd0:    res = z;
            4'd1:    res = ~z;
            4'd2:    res = c;
            4'd3:    res = ~c;
            4'd4:    res = n;
            4'd5:    res = ~n;
            4'd6:    res = v;
            4'd7:    res = ~v;
            4'd8:    res = c & ~z;
            4'd9:    res = ~c | z;
            4'd10:   res = (n == v);
            4'd11:   res = (n != v);
            4'd12:   res = ~z & (n == v);
            4'd13:   res = z | (n != v);
            4'd14:   res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Condition selection and execute gating for the current instruction
    always_comb begin
        active      = (state_q == ST_ACTIVE);
        consume     = instr_valid & ~stall & ~flush;
        // Inside a block the condition comes from the IT instruction: the
        // mask LSB selects then (firstcond) or else (firstcond LSB flipped).
        eff_cond    = active ? {firstcond_q[3:1], firstcond_q[0] ^ ~mask_q[0]}
                             : instr_cond;
        cond_pass   = cond_truth(eff_cond, status_q);
        exec_en     = instr_valid & ~flush & cond_pass;
        len_clamped = (it_len > IT_MAX_L) ? IT_MAX_L : it_len;
    end

    // Next-state logic for flags, IT sequencer and nested-IT error pulse
    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        firstcond_d = firstcond_q;
        mask_d      = mask_q;
        rem_d       = rem_q;
        it_err_d    = 1'b0;

        if (flush) begin
            // Flush kills the instruction (no flag write) and abandons any block,
            // even while stalled.
            state_d = ST_IDLE;
            rem_d   = '0;
            mask_d  = '0;
        end else if (consume) begin
            if (active) begin
                // Every consumed instruction uses a slot, pass or fail; a nested
                // IT is just another covered instruction that flags an error.
                rem_d    = rem_q - ONE_L;
                mask_d   = mask_q >> 1;
                it_err_d = it_start;
                if (rem_q == ONE_L) begin
                    state_d = ST_IDLE;
                    mask_d  = '0;
                end
            end else if (it_start && (it_len != '0)) begin
                state_d     = ST_ACTIVE;
                firstcond_d = it_firstcond;
                mask_d      = it_tmask;
                mask_d[0]   = 1'b1;
                rem_d       = len_clamped;
            end

            if (exec_en && status_we) begin
                status_d = status_in;
            end
        end
    end

    // State registers; stall holds everything simply by not consuming
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            status_q    <= RESET_STATUS;
            firstcond_q <= 4'd0;
            mask_q      <= '0;
            rem_q       <= '0;
            it_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            firstcond_q <= firstcond_d;
            mask_q      <= mask_d;
            rem_q       <= rem_d;
            it_err_q    <= it_err_d;
        end
    end

    assign status_out   = status_q;
    assign in_it        = active;
    assign it_remaining = rem_q;
    assign it_err       = it_err_q;

endmodule

// File: tb/tb_cond_exec_unit.sv
// Directed bench for cond_exec_unit: flag truth table, flag latency,
// IT sequencing, stall/bubble hold, flush, nested IT, clamp and async reset.
module tb_cond_exec_unit;

    localparam int         IT_MAX = 4;
    localparam int         LW     = $clog2(IT_MAX + 1);
    localparam logic [3:0] RST_ST = 4'b0000;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              flush;
    logic              instr_valid;
    logic [3:0]        instr_cond;
    logic              it_start;
    logic [3:0]        it_firstcond;
    logic [LW-1:0]     it_len;
    logic [IT_MAX-1:0] it_tmask;
    logic              status_we;
    logic [3:0]        status_in;
    logic [3:0]        status_out;
    logic              exec_en;
    logic [3:0]        eff_cond;
    logic              in_it;
    logic [LW-1:0]     it_remaining;
    logic              it_err;

    int checks = 0;
    int errors = 0;

    cond_exec_unit #(.IT_MAX(IT_MAX), .RESET_STATUS(RST_ST)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .instr_valid  (instr_valid),
        .instr_cond   (instr_cond),
        .it_start     (it_start),
        .it_firstcond (it_firstcond),
        .it_len       (it_len),
        .it_tmask     (it_tmask),
        .status_we    (status_we),
        .status_in    (status_in),
        .status_out   (status_out),
        .exec_en      (exec_en),
        .eff_cond     (eff_cond),
        .in_it        (in_it),
        .it_remaining (it_remaining),
        .it_err       (it_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference condition table written directly from the ARM definitions
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c)
            4'd0:  return z == 1'b1;
            4'd1:  return z == 1'b0;
            4'd2:  return cc == 1'b1;
            4'd3:  return cc == 1'b0;
            4'd4:  return n == 1'b1;
            4'd5:  return n == 1'b0;
            4'd6:  return v == 1'b1;
            4'd7:  return v == 1'b0;
            4'd8:  return (cc == 1'b1) && (z == 1'b0);
            4'd9:  return (cc == 1'b0) || (z == 1'b1);
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return (z == 1'b0) && (n == v);
            4'd13: return (z == 1'b1) || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; instr_valid = 0; instr_cond = 4'd14;
        it_start = 0; it_firstcond = 4'd0; it_len = '0; it_tmask = '0;
        status_we = 0; status_in = 4'd0;
    endtask

    // Write flags through an always-executing instruction
    task automatic load_status(input logic [3:0] s);
        idle_inputs();
        instr_valid = 1; instr_cond = 4'd14; status_we = 1; status_in = s;
        tick();
        idle_inputs();
        #1;
    endtask

    // Consume an IT instruction
    task automatic start_it(input logic [3:0] fc, input logic [LW-1:0] len, input logic [IT_MAX-1:0] tm);
        idle_inputs();
        instr_valid = 1; it_start = 1; it_firstcond = fc; it_len = len; it_tmask = tm;
        tick();
        idle_inputs();
        #1;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        #12;
        check("rst_status", status_out, RST_ST);
        check("rst_in_it", in_it, 0);
        check("rst_rem", it_remaining, 0);
        check("rst_err", it_err, 0);
        rst = 0;
        #1;

        // Truth-table sweep, outside any IT block
        for (int s = 0; s < 16; s++) begin
            load_status(4'(s));
            check("sweep_status", status_out, s);
            instr_valid = 1;
            for (int c = 0; c < 16; c++) begin
                instr_cond = 4'(c);
                #1;
                check($sformatf("truth_s%0d_c%0d", s, c), exec_en, ref_cond(4'(c), 4'(s)));
                check("eff_idle", eff_cond, c);
            end
            idle_inputs();
            #1;
        end

        // Flag latency: written at the edge, seen by the next instruction
        load_status(4'b0000);
        instr_valid = 1; instr_cond = 4'd14; status_we = 1; status_in = 4'b0100;
        #1;
        check("lat_old_status", status_out, 4'b0000);
        tick();
        check("lat_new_status", status_out, 4'b0100);
        status_we = 0; instr_cond = 4'd0;
        #1;
        check("lat_eq_pass", exec_en, 1);
        // Failing instruction must not write flags
        instr_cond = 4'd1; status_we = 1; status_in = 4'b1111;
        #1;
        check("nowr_exec", exec_en, 0);
        tick();
        check("nowr_status", status_out, 4'b0100);

        // IT EQ, len 3, then-else-then, Z=1
        start_it(4'd0, 3'd3, 4'b0101);
        check("it_in", in_it, 1);
        check("it_rem3", it_remaining, 3);
        instr_valid = 1; instr_cond = 4'd15;
        #1;
        check("it1_eff", eff_cond, 4'd0);
        check("it1_exec", exec_en, 1);
        tick();
        check("it_rem2", it_remaining, 2);
        check("it2_eff", eff_cond, 4'd1);
        check("it2_exec", exec_en, 0);
        tick();
        check("it_rem1", it_remaining, 1);
        check("it3_eff", eff_cond, 4'd0);
        check("it3_exec", exec_en, 1);
        tick();
        check("it_rem0", it_remaining, 0);
        check("it_done", in_it, 0);
        check("it_after_eff", eff_cond, 4'd15);
        check("it_after_exec", exec_en, 0);

        // len=0 is a no-op
        start_it(4'd0, 3'd0, 4'b0001);
        check("len0_in", in_it, 0);
        check("len0_rem", it_remaining, 0);

        // Stall and bubble hold; AL in else slot becomes NV
        start_it(4'd14, 3'd2, 4'b0001);
        instr_valid = 1; stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_rem", it_remaining, 2);
            check("stall_in", in_it, 1);
        end
        check("stall_exec_comb", exec_en, 1);
        stall = 0; instr_valid = 0;
        tick();
        check("bubble_rem", it_remaining, 2);
        instr_valid = 1;
        #1;
        check("al_then_eff", eff_cond, 4'd14);
        tick();
        check("al_rem1", it_remaining, 1);
        check("al_else_eff", eff_cond, 4'd15);
        check("al_else_exec", exec_en, 0);
        tick();
        check("al_done", in_it, 0);

        // Flush after first covered instruction; flush beats it_start
        start_it(4'd0, 3'd3, 4'b0111);
        instr_valid = 1;
        tick();
        check("fl_rem2", it_remaining, 2);
        flush = 1; it_start = 1; it_len = 3'd2; it_tmask = 4'b0001;
        status_we = 1; status_in = 4'b1111;
        #1;
        check("fl_exec", exec_en, 0);
        tick();
        check("fl_in", in_it, 0);
        check("fl_rem", it_remaining, 0);
        check("fl_status", status_out, 4'b0100);
        idle_inputs();
        instr_valid = 1; instr_cond = 4'd15;
        #1;
        check("fl_nv", exec_en, 0);
        instr_cond = 4'd14;
        #1;
        check("fl_al", exec_en, 1);

        // Nested IT: error pulse, normal decrement, no reload
        start_it(4'd14, 3'd3, 4'b0111);
        instr_valid = 1; it_start = 1; it_firstcond = 4'd1; it_len = 3'd4;
        tick();
        check("nest_err", it_err, 1);
        check("nest_rem", it_remaining, 2);
        check("nest_eff", eff_cond, 4'd14);
        idle_inputs();
        tick();
        check("nest_err_clr", it_err, 0);
        check("nest_rem_hold", it_remaining, 2);
        instr_valid = 1;
        tick(); tick();
        check("nest_done", in_it, 0);

        // Length clamp, then asynchronous reset mid-block
        start_it(4'd0, 3'd7, 4'b1111);
        check("clamp_rem", it_remaining, 4);
        check("pre_rst_status", status_out, 4'b0100);
        #2;
        rst = 1;
        #1;
        check("arst_status", status_out, RST_ST);
        check("arst_in", in_it, 0);
        check("arst_rem", it_remaining, 0);
        rst = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
